// File: rtl/demux_32_1_2.sv
// One-to-two 32-bit demultiplexer: each word is steered to output A or B by in_sel and held in a 2-entry FIFO per output.
// Optional per-output transfer counters are built only when DEMUX_XFER_CNT_EN is defined.
module demux_32_1_2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sel,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] a_data,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [31:0] b_data,
  output logic [15:0] a_xfer_cnt,
  output logic [15:0] b_xfer_cnt
);

  localparam int DEPTH = 2;

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and its data stable until that edge, and ready never
  // depends on the valid it is paired with.

  logic [31:0] a_mem [DEPTH];
  logic [31:0] b_mem [DEPTH];
  logic        a_wr, a_rd, b_wr, b_rd;
  logic [1:0]  a_count, b_count;
  logic        a_full, b_full;
  logic        a_push, a_pop, b_push, b_pop;

  assign a_full   = (a_count == 2'(DEPTH));
  assign b_full   = (b_count == 2'(DEPTH));
  // Ready looks only at the registered count of the target, so a full buffer
  // never passes a word through even when it is being popped this cycle.
  assign in_ready = in_sel ? !b_full : !a_full;

  assign a_push  = in_valid && in_ready && !in_sel;
  assign b_push  = in_valid && in_ready &&  in_sel;
  assign a_valid = (a_count != 2'd0);
  assign b_valid = (b_count != 2'd0);
  assign a_pop   = a_valid && a_ready;
  assign b_pop   = b_valid && b_ready;
  assign a_data  = a_mem[a_rd];
  assign b_data  = b_mem[b_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_wr    <= 1'b0;
      a_rd    <= 1'b0;
      a_count <= 2'd0;
      b_wr    <= 1'b0;
      b_rd    <= 1'b0;
      b_count <= 2'd0;
    end else begin
      if (a_push) a_wr <= ~a_wr;
      if (a_pop)  a_rd <= ~a_rd;
      if (a_push && !a_pop)      a_count <= a_count + 2'd1;
      else if (!a_push && a_pop) a_count <= a_count - 2'd1;
      if (b_push) b_wr <= ~b_wr;
      if (b_pop)  b_rd <= ~b_rd;
      if (b_push && !b_pop)      b_count <= b_count + 2'd1;
      else if (!b_push && b_pop) b_count <= b_count - 2'd1;
    end
  end

  // Storage is left unreset; valid is derived from the counts alone.
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wr] <= in_data;
    if (b_push) b_mem[b_wr] <= in_data;
  end

`ifdef DEMUX_XFER_CNT_EN
  logic [15:0] a_cnt_q, b_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= 16'h0000;
      b_cnt_q <= 16'h0000;
    end else begin
      if (a_pop && (a_cnt_q != 16'hFFFF)) a_cnt_q <= a_cnt_q + 16'd1;
      if (b_pop && (b_cnt_q != 16'hFFFF)) b_cnt_q <= b_cnt_q + 16'd1;
    end
  end

  assign a_xfer_cnt = a_cnt_q;
  assign b_xfer_cnt = b_cnt_q;
`else
  assign a_xfer_cnt = 16'h0000;
  assign b_xfer_cnt = 16'h0000;
`endif

endmodule
